xtal_clock_qualifier: RTL
=========================

// Module: xtal_clock_qualifier
// PURPOSE
//  Downstream of the crystal oscillator model. Consumes the complementary pair:
//   ClockP drives the Clock port; ClockN is sampled as data.
//  Holds off ClockReady until the oscillator has produced a run of good
//   complementary cycles. Drops ClockReady on loss of complementarity, then
//   retries.
//  Once locked, produces a divided clock and a one-cycle tick for the
//   slower digit logic.
// PARAMETERS
//  WARMUP_CYCLES  1024  consecutive good samples required before lock
//  FAULT_LIMIT    4     consecutive bad samples in LOCKED that declare a fault
//  RETRY_CYCLES   256   cycles spent in FAULT before WARMUP is re-entered
//  DIV_RATIO      8     ClockDiv period in Clock cycles; even, >=2
//  CNT_W          16    width of the warmup/retry counter; must hold max(WARMUP_CYCLES, RETRY_CYCLES)
// PORTS
//  Clock       in   1      ClockP from the oscillator; only clock; all flops on posedge
//  Reset       in   1      asynchronous, active-high; one clock, no other resets
//  ClockN      in   1      complementary oscillator output, sampled as data
//  ClockReady  out  1      1 while state==LOCKED
//  ClockFault  out  1      1 while state==FAULT
//  ClockDiv    out  1      Clock/DIV_RATIO, 50% duty; 0 outside LOCKED
//  Tick        out  1      one-cycle pulse on each ClockDiv rising edge
//  FaultCount  out  8      number of LOCKED->FAULT entries, saturates at 255
// BEHAVIOUR
//  Reset asserted: all outputs 0; counters 0; state IDLE; synchroniser flops = 1.
//   Reset is asynchronous, so a mid-operation assertion clears outputs immediately.
//  Sample = ClockN after a 2-flop synchroniser. Good = (Sample==0); Bad = (Sample==1).
//  States (registered; all outputs registered, decoded from state/next-state on same edge):
//   IDLE:   -> WARMUP on the first edge; cnt=0.
//   WARMUP: Good -> cnt++; Bad -> cnt=0.
//           Good with cnt==WARMUP_CYCLES-1 -> LOCKED; ClockReady=1 from that edge.
//   LOCKED: badrun++ on Bad; badrun=0 on Good.
//           Bad with badrun==FAULT_LIMIT-1 -> FAULT on that edge: ClockReady=0,
//            ClockFault=1, FaultCount++ (sat).
//   FAULT:  cnt++ each cycle, Sample ignored.
//           cnt==RETRY_CYCLES-1 -> WARMUP with cnt=0; ClockFault=0 on that edge.
//  Divider: d counts 0..DIV_RATIO-1, only in LOCKED. On LOCKED entry d=0, ClockDiv=0.
//   ClockDiv toggles on edges where d==DIV_RATIO/2-1 or d==DIV_RATIO-1.
//   Tick=1 for exactly the cycle after each 0->1 toggle.
//  Leaving LOCKED: ClockDiv=0, Tick=0, d=0 on the same edge; no runt high phase beyond that edge.
//  Boundaries:
//   - Bad on the terminal WARMUP cycle: Bad wins, cnt=0, no lock.
//   - Good on the FAULT_LIMIT-th cycle clears badrun; no fault.
//   - FaultCount at 255 stays 255.
//   - Retry counter wrap never occurs; the state changes first.
// STRUCTURE
//  Package xtal_clock_pkg: state encoding localparams (IDLE, WARMUP, LOCKED, FAULT)
//   and a function checking DIV_RATIO even and >=2, used by an elaboration check.
//  Sub-module clock_divider_tick (Clock, Reset, Enable, ClockDiv, Tick):
//   Enable = (next state == LOCKED).
//  Everything else stays in this module: FSM, synchroniser, counters.
// TESTING (WARMUP_CYCLES=16, FAULT_LIMIT=4, RETRY_CYCLES=8, DIV_RATIO=4)
//  1. ClockN=0 constant from Reset release
//     -> ClockReady rises after the 18th rising edge; ClockFault stays 0.
//  2. ClockN=1 for 1 cycle mid-warmup
//     -> cnt restarts; ClockReady delayed by the samples lost; no fault.
//  3. Locked, ClockN=1 for 3 cycles then 0
//     -> no fault; 4 cycles of 1 -> ClockReady=0, ClockFault=1, FaultCount=1.
//  4. After fault
//     -> ClockFault=1 for exactly 8 cycles, then WARMUP; relock after 16 good samples.
//  5. Locked
//     -> ClockDiv pattern 0,0,1,1 repeating; Tick one cycle per 4; ClockDiv=0
//        the edge ClockReady drops.
//  6. Reset asserted while LOCKED mid-ClockDiv-high
//     -> all outputs 0 without a clock edge; 256 forced faults leave FaultCount=255.

Source files
------------

// File: rtl/xtal_clock_pkg.sv
// Shared encodings and parameter checks for the crystal clock qualifier.
// State constants stay plain 2-bit localparams so older tools can consume them.
package xtal_clock_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    // The divider needs a whole number of cycles in each half-period.
    function automatic bit div_ratio_ok(input int ratio);
        return (ratio >= 2) && ((ratio % 2) == 0);
    endfunction

endpackage

// File: rtl/clock_divider_tick.sv
// 50% duty clock divider with a one-cycle tick after each rising toggle.
// Runs only while Enable is high; dropping Enable clears everything on that edge.
module clock_divider_tick #(
    parameter int DIV_RATIO = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    output logic ClockDiv,
    output logic Tick
);

    localparam int D_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
    localparam logic [D_W-1:0] HALF_LAST = D_W'(DIV_RATIO / 2 - 1);
    localparam logic [D_W-1:0] LAST      = D_W'(DIV_RATIO - 1);

    logic [D_W-1:0] d;
    logic           running;
    logic           toggle;

    assign toggle = (d == HALF_LAST) || (d == LAST);

    // The first enabled edge only loads d=0 so every locked period starts aligned.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            d        <= '0;
            running  <= 1'b0;
            ClockDiv <= 1'b0;
            Tick     <= 1'b0;
        end else if (!Enable) begin
            d        <= '0;
            running  <= 1'b0;
            ClockDiv <= 1'b0;
            Tick     <= 1'b0;
        end else if (!running) begin
            d        <= '0;
            running  <= 1'b1;
            ClockDiv <= 1'b0;
            Tick     <= 1'b0;
        end else begin
            d        <= (d == LAST) ? '0 : d + D_W'(1);
            ClockDiv <= toggle ? ~ClockDiv : ClockDiv;
            Tick     <= toggle && !ClockDiv;
        end
    end

endmodule

// File: rtl/xtal_clock_qualifier.sv
// Qualifies the oscillator by watching ClockN stay complementary to the clock,
// gating ClockReady, flagging faults with a retry hold-off, and driving the divider.
module xtal_clock_qualifier
    import xtal_clock_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1024,
    parameter int FAULT_LIMIT   = 4,
    parameter int RETRY_CYCLES  = 256,
    parameter int DIV_RATIO     = 8,
    parameter int CNT_W         = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ClockN,
    output logic       ClockReady,
    output logic       ClockFault,
    output logic       ClockDiv,
    output logic       Tick,
    output logic [7:0] FaultCount,
    output logic [1:0] DebugState
);

    localparam int BR_W = $clog2(FAULT_LIMIT + 1);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYCLES - 1);
    localparam logic [BR_W-1:0]  FAULT_LAST = BR_W'(FAULT_LIMIT - 1);

    if (!div_ratio_ok(DIV_RATIO)) begin : g_bad_div_ratio
        $error("xtal_clock_qualifier: DIV_RATIO must be even and >= 2");
    end

    logic             sync1;
    logic             sync2;
    logic             bad;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [BR_W-1:0]  badrun;
    logic [BR_W-1:0]  badrun_next;

    // A high ClockN while ClockP is rising means the pair lost complementarity.
    assign bad        = sync2;
    assign DebugState = state;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        badrun_next = badrun;
        case (state)
            ST_IDLE: begin
                state_next  = ST_WARMUP;
                cnt_next    = '0;
                badrun_next = '0;
            end
            ST_WARMUP: begin
                if (bad) begin
                    cnt_next = '0;
                end else if (cnt == WARM_LAST) begin
                    state_next  = ST_LOCKED;
                    cnt_next    = '0;
                    badrun_next = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!bad) begin
                    badrun_next = '0;
                end else if (badrun == FAULT_LAST) begin
                    state_next  = ST_FAULT;
                    cnt_next    = '0;
                    badrun_next = '0;
                end else begin
                    badrun_next = badrun + BR_W'(1);
                end
            end
            ST_FAULT: begin
                if (cnt == RETRY_LAST) begin
                    state_next = ST_WARMUP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Synchroniser resets to 1 so the first samples after reset count as bad.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state      <= ST_IDLE;
            cnt        <= '0;
            badrun     <= '0;
            ClockReady <= 1'b0;
            ClockFault <= 1'b0;
            FaultCount <= 8'd0;
        end else begin
            sync1      <= ClockN;
            sync2      <= sync1;
            state      <= state_next;
            cnt        <= cnt_next;
            badrun     <= badrun_next;
            ClockReady <= (state_next == ST_LOCKED);
            ClockFault <= (state_next == ST_FAULT);
            if ((state == ST_LOCKED) && (state_next == ST_FAULT) && (FaultCount != 8'hFF)) begin
                FaultCount <= FaultCount + 8'd1;
            end
        end
    end

    clock_divider_tick #(
        .DIV_RATIO(DIV_RATIO)
    ) u_divider (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (state_next == ST_LOCKED),
        .ClockDiv(ClockDiv),
        .Tick    (Tick)
    );

endmodule
